// File: rtl/dds_modulator.sv
// DDS carrier generator with ASK / continuous-phase FSK / BPSK keying from a handshaked bit stream.
// Samples emerge 4 cycles after each en tick; sine/cosine come from an external 1-cycle ROM.
module dds_modulator #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned AMP_W   = 12,
  parameter int unsigned LUT_AW  = 10,
  parameter int unsigned SYM_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PHASE_W-1:0] tw0,
  input  logic [PHASE_W-1:0] tw1,
  input  logic [1:0]         signal_sel,
  input  logic [1:0]         modulation_sel,
  input  logic [SYM_W-1:0]   sym_len,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic [LUT_AW-1:0]  rom_addr,
  input  logic [AMP_W-1:0]   rom_data,
  output logic [AMP_W-1:0]   carrier_out,
  output logic [AMP_W-1:0]   sample_out,
  output logic               sample_valid,
  output logic               cur_bit,
  output logic               underrun
);

  typedef enum logic [1:0] {SIG_SINE, SIG_COS, SIG_SQUARE, SIG_SAW} sig_e;
  typedef enum logic [1:0] {MOD_NONE, MOD_ASK, MOD_FSK, MOD_BPSK} mod_e;
  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [AMP_W-1:0]  MAX     = {1'b0, {(AMP_W-1){1'b1}}};
  localparam logic [AMP_W-1:0]  MIN     = {1'b1, {(AMP_W-1){1'b0}}};
  localparam logic [AMP_W-1:0]  NEG_MAX = MIN + AMP_W'(1);
  localparam logic [LUT_AW-1:0] QTR     = LUT_AW'(1) << (LUT_AW - 2);

  state_e             state;
  logic [SYM_W-1:0]   cnt;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] tw;
  logic               accept;

  sig_e               sel_a, sel_b, sel_c;
  mod_e               mod_a, mod_b, mod_c, mod_d;
  logic               bit_a, bit_b, bit_c, bit_d;
  logic               v_a, v_b, v_c, v_d;
  logic [AMP_W-1:0]   alt_b, alt_c, car_d;
  logic [AMP_W-1:0]   mod_out;

  always_comb begin
    bit_ready = (state == IDLE) || (en && (cnt == '0));
    accept    = bit_valid && bit_ready;
    tw        = ((mod_e'(modulation_sel) == MOD_FSK) && cur_bit) ? tw1 : tw0;
  end

  // Symbol FSM; a symbol ending on an en tick may take the next bit back-to-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_bit  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cur_bit <= bit_in;
          cnt     <= (sym_len == '0) ? '0 : sym_len - SYM_W'(1);
          state   <= RUN;
        end
        RUN: if (en) begin
          if (cnt != '0) begin
            cnt <= cnt - SYM_W'(1);
          end else if (bit_valid) begin
            cur_bit <= bit_in;
            cnt     <= (sym_len == '0) ? '0 : sym_len - SYM_W'(1);
          end else begin
            cur_bit  <= 1'b0;
            underrun <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mod_out = car_d;
    case (mod_d)
      MOD_ASK:  mod_out = bit_d ? car_d : '0;
      MOD_BPSK: if (bit_d) mod_out = (car_d == MIN) ? MAX : -car_d;
      default:  mod_out = car_d;
    endcase
  end

  // Stage a captures at the tick edge; later stages read the phase written by that tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase        <= '0;
      v_a          <= 1'b0;
      v_b          <= 1'b0;
      v_c          <= 1'b0;
      v_d          <= 1'b0;
      sel_a        <= SIG_SINE;
      sel_b        <= SIG_SINE;
      sel_c        <= SIG_SINE;
      mod_a        <= MOD_NONE;
      mod_b        <= MOD_NONE;
      mod_c        <= MOD_NONE;
      mod_d        <= MOD_NONE;
      bit_a        <= 1'b0;
      bit_b        <= 1'b0;
      bit_c        <= 1'b0;
      bit_d        <= 1'b0;
      alt_b        <= '0;
      alt_c        <= '0;
      car_d        <= '0;
      rom_addr     <= '0;
      carrier_out  <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      if (en) begin
        phase <= phase + tw;
        sel_a <= sig_e'(signal_sel);
        mod_a <= mod_e'(modulation_sel);
        bit_a <= cur_bit;
      end
      v_a <= en;

      v_b      <= v_a;
      sel_b    <= sel_a;
      mod_b    <= mod_a;
      bit_b    <= bit_a;
      rom_addr <= phase[PHASE_W-1 -: LUT_AW] + ((sel_a == SIG_COS) ? QTR : '0);
      alt_b    <= (sel_a == SIG_SQUARE) ? (phase[PHASE_W-1] ? NEG_MAX : MAX)
                                        : {~phase[PHASE_W-1], phase[PHASE_W-2 -: AMP_W-1]};

      v_c   <= v_b;
      sel_c <= sel_b;
      mod_c <= mod_b;
      bit_c <= bit_b;
      alt_c <= alt_b;

      v_d   <= v_c;
      mod_d <= mod_c;
      bit_d <= bit_c;
      car_d <= ((sel_c == SIG_SINE) || (sel_c == SIG_COS)) ? rom_data : alt_c;

      sample_valid <= v_d;
      carrier_out  <= car_d;
      sample_out   <= mod_out;
    end
  end

endmodule

// File: tb/tb_dds_modulator.sv
// Directed bench for dds_modulator: expected samples are queued at each en tick and
// compared when sample_valid appears; handshake, phase and status checks are inline.
module tb_dds_modulator;
  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] tw0, tw1;
  logic [1:0]  signal_sel, modulation_sel;
  logic [15:0] sym_len;
  logic        bit_in, bit_valid, bit_ready;
  logic [9:0]  rom_addr;
  logic [11:0] rom_data;
  logic [11:0] carrier_out, sample_out;
  logic        sample_valid, cur_bit, underrun;

  int checks = 0;
  int errors = 0;
  int exp_s[$];
  int exp_c[$];
  logic        rom_force = 1'b0;
  logic [31:0] mphase;

  dds_modulator #(.PHASE_W(32), .AMP_W(12), .LUT_AW(10), .SYM_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .tw0(tw0), .tw1(tw1),
    .signal_sel(signal_sel), .modulation_sel(modulation_sel), .sym_len(sym_len),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .rom_addr(rom_addr), .rom_data(rom_data), .carrier_out(carrier_out),
    .sample_out(sample_out), .sample_valid(sample_valid), .cur_bit(cur_bit),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Sine ROM stand-in with a registered read; rom_force pins it at full-scale negative.
  always @(posedge clk) rom_data <= rom_force ? 12'h800 : {rom_addr, 2'b00};

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int saw(input logic [31:0] p);
    return int'(p[31:20]) - 2048;
  endfunction

  task automatic push(input int s, input int c);
    exp_s.push_back(s);
    exp_c.push_back(c);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && exp_s.size() != 0; i++) @(negedge clk);
    chk("drain_pending", exp_s.size(), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    exp_s.delete();
    exp_c.delete();
    @(negedge clk);
    reset  = 1'b1;
    mphase = '0;
  endtask

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      if (exp_s.size() == 0) begin
        chk("spurious_sample_valid", sample_valid, 0);
      end else begin
        chk("sample_out", $signed(sample_out), exp_s.pop_front());
        chk("carrier_out", $signed(carrier_out), exp_c.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; en = 1'b0; tw0 = 32'h0100_0000; tw1 = '0;
    signal_sel = 2'b11; modulation_sel = 2'b00; sym_len = '0;
    bit_in = 1'b0; bit_valid = 1'b0; mphase = '0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en = ~en;
      #1;
      chk("rst_sample_out", sample_out, 0);
      chk("rst_carrier_out", carrier_out, 0);
      chk("rst_sample_valid", sample_valid, 0);
      chk("rst_cur_bit", cur_bit, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_bit_ready", bit_ready, 1);
    end
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;

    // Single tick: sample_valid must appear only after edge k+4.
    @(negedge clk);
    en = 1'b1;
    mphase += tw0;
    push(saw(mphase), saw(mphase));
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      chk("latency_valid", sample_valid, (i == 4));
      @(negedge clk);
    end

    // Sawtooth, en every cycle, spanning more than one wrap.
    for (int i = 0; i < 300; i++) begin
      en = 1'b1;
      mphase += tw0;
      push(saw(mphase), saw(mphase));
      @(negedge clk);
    end
    en = 1'b0;
    drain();

    // BPSK with ROM at -2048: negation saturates.
    pulse_reset();
    signal_sel = 2'b00; modulation_sel = 2'b11; rom_force = 1'b1; sym_len = 16'd8;
    bit_in = 1'b1; bit_valid = 1'b1; en = 1'b0;
    #1 chk("bpsk_ready_idle", bit_ready, 1);
    @(negedge clk);
    bit_valid = 1'b0;
    chk("bpsk_cur_bit", cur_bit, 1);
    en = 1'b1;
    push(2047, -2048);
    @(negedge clk);
    en = 1'b0;
    drain();

    // CP-FSK: bits 1 then 0 back-to-back, sym_len=2.
    pulse_reset();
    rom_force = 1'b0;
    tw0 = 32'd100; tw1 = 32'd300; modulation_sel = 2'b10; signal_sel = 2'b11; sym_len = 16'd2;
    bit_in = 1'b1; bit_valid = 1'b1; en = 1'b0;
    #1 chk("fsk_ready_idle", bit_ready, 1);
    @(negedge clk);
    bit_in = 1'b0; en = 1'b1;
    #1 chk("fsk_ready_t1", bit_ready, 0);
    push(-2048, -2048);
    @(negedge clk);
    chk("fsk_phase_1", dut.phase, 300);
    #1 chk("fsk_ready_t2", bit_ready, 1);
    push(-2048, -2048);
    @(negedge clk);
    chk("fsk_phase_2", dut.phase, 600);
    chk("fsk_cur_bit_0", cur_bit, 0);
    bit_valid = 1'b0;
    #1 chk("fsk_ready_t3", bit_ready, 0);
    push(-2048, -2048);
    @(negedge clk);
    chk("fsk_phase_3", dut.phase, 700);
    #1 chk("fsk_ready_t4", bit_ready, 1);
    chk("fsk_underrun_pre", underrun, 0);
    push(-2048, -2048);
    @(negedge clk);
    chk("fsk_phase_4", dut.phase, 800);
    en = 1'b0;
    chk("fsk_underrun", underrun, 1);
    drain();

    // ASK on square with a single bit, then underrun.
    pulse_reset();
    tw0 = 32'h0100_0000; signal_sel = 2'b10; modulation_sel = 2'b01; sym_len = 16'd3;
    bit_in = 1'b1; bit_valid = 1'b1; en = 1'b0;
    @(negedge clk);
    bit_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = 1'b1;
      push((i < 3) ? 2047 : 0, 2047);
      #1;
      chk("ask_bit_ready", bit_ready, (i >= 2));
      chk("ask_underrun", underrun, (i >= 3));
      @(negedge clk);
    end
    en = 1'b0;
    chk("ask_underrun_end", underrun, 1);
    chk("ask_ready_end", bit_ready, 1);
    chk("ask_cur_bit_end", cur_bit, 0);
    drain();

    // sym_len=0: one tick per bit; then reset while running.
    pulse_reset();
    sym_len = '0; modulation_sel = 2'b00; signal_sel = 2'b11;
    bit_in = 1'b1; bit_valid = 1'b1; en = 1'b0;
    @(negedge clk);
    chk("len0_first_bit", cur_bit, 1);
    for (int i = 0; i < 4; i++) begin
      en = 1'b1;
      bit_in = i[0];
      #1 chk("len0_ready", bit_ready, 1);
      mphase += tw0;
      push(saw(mphase), saw(mphase));
      @(negedge clk);
      chk("len0_cur_bit", cur_bit, i[0]);
    end
    #2;
    reset = 1'b0;
    en = 1'b0;
    bit_valid = 1'b0;
    exp_s.delete();
    exp_c.delete();
    #1;
    chk("midrst_cur_bit", cur_bit, 0);
    chk("midrst_underrun", underrun, 0);
    chk("midrst_phase", dut.phase, 0);
    chk("midrst_bit_ready", bit_ready, 1);
    chk("midrst_valid", sample_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    mphase = '0;
    repeat (6) @(negedge clk);
    en = 1'b1;
    mphase += tw0;
    push(saw(mphase), saw(mphase));
    @(negedge clk);
    en = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
